// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and round primitives for the iterative encryptor.
// Build option AES_256_EN selects 14 rounds (AES-256); otherwise 10 rounds (AES-128).
package aes_pkg;

  localparam int BLOCK_LENGTH = 128;
  localparam int RK_IDX_W     = 4;
  localparam int NR_128       = 10;
  localparam int NR_256       = 14;

`ifdef AES_256_EN
  localparam int AES_NR = NR_256;
`else
  localparam int AES_NR = NR_128;
`endif

  localparam logic [RK_IDX_W-1:0] NR_IDX     = RK_IDX_W'(AES_NR);
  localparam logic [RK_IDX_W-1:0] LAST_ROUND = RK_IDX_W'(AES_NR - 1);

  // Sparse encoding leaves unused codes so a corrupted state is detectable.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_ROUND = 3'b001,
    S_FINAL = 3'b010,
    S_DONE  = 3'b100
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] sub_bytes(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return r;
  endfunction

  // Byte n sits at row n%4, column n/4 (column-major, byte 0 in the MSBs).
  function automatic logic [BLOCK_LENGTH-1:0] shift_rows(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
    return r;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] mix_columns(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] key_add(input logic [BLOCK_LENGTH-1:0] s,
                                                      input logic [BLOCK_LENGTH-1:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (skipped in the last round) -> AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [BLOCK_LENGTH-1:0] state,
  input  logic [BLOCK_LENGTH-1:0] round_key,
  input  logic                    is_final,
  output logic [BLOCK_LENGTH-1:0] next_state
);

  logic [BLOCK_LENGTH-1:0] sb;
  logic [BLOCK_LENGTH-1:0] sr;
  logic [BLOCK_LENGTH-1:0] mc;

  assign sb         = sub_bytes(state);
  assign sr         = shift_rows(sb);
  assign mc         = mix_columns(sr);
  assign next_state = key_add(is_final ? sr : mc, round_key);

endmodule

// File: rtl/aes_iter_round_ctrl.sv
// Iterative AES encryptor: one shared round datapath stepped NR times per block.
// Define AES_256_EN for AES-256 (14 rounds); default build is AES-128 (10 rounds).
module aes_iter_round_ctrl
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_data,
  output logic [RK_IDX_W-1:0]     rk_idx,
  input  logic [BLOCK_LENGTH-1:0] rk_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic                    busy
);

  state_e                  fsm;
  logic [RK_IDX_W-1:0]     cnt;
  logic [BLOCK_LENGTH-1:0] state_q;
  logic [BLOCK_LENGTH-1:0] round_out;
  logic                    accept;

  // NOTE: in_ready is deliberately combinational on out_ready so a draining block and a
  // new accept share one edge; this is what gives the NR+1 cycle back-to-back rate.
  assign in_ready = (fsm == S_IDLE) | ((fsm == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // The counter doubles as the key index: it is 0 in IDLE/DONE, so key 0 is already presented at accept.
  assign rk_idx   = cnt;
  assign out_data = state_q;

  aes_round_dp u_round_dp (
    .state      (state_q),
    .round_key  (rk_data),
    .is_final   (fsm == S_FINAL),
    .next_state (round_out)
  );

  // NOTE: sequential state uses non-blocking assignments only; the 128-bit state register
  // is reset as well because out_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      state_q   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q   <= in_data ^ rk_data;
            cnt       <= RK_IDX_W'(1);
            fsm       <= S_ROUND;
            busy      <= 1'b1;
            out_valid <= 1'b0;
          end else if (fsm == S_DONE && out_ready) begin
            fsm       <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_ROUND: begin
          state_q <= round_out;
          cnt     <= cnt + 1'b1;
          if (cnt >= LAST_ROUND) fsm <= S_FINAL;
        end
        S_FINAL: begin
          state_q   <= round_out;
          cnt       <= '0;
          fsm       <= S_DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        default: begin
          fsm       <= S_IDLE;
          cnt       <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_round_ctrl.sv
// Self-checking bench for aes_iter_round_ctrl: FIPS-197 key ROM, block-level AES reference model.
`timescale 1ns/1ps
module tb_aes_iter_round_ctrl;

`ifdef AES_256_EN
  localparam int NR = 14;
  localparam int NK = 8;
  localparam logic [255:0] KEY     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
`else
  localparam int NR = 10;
  localparam int NK = 4;
  localparam logic [255:0] KEY     = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`endif
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [127:0] rk_rom [16];
  logic [7:0]   sbox_t [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Block-level model: idle, or active with a count of edges since the accept edge.
  bit           m_active;
  int           m_age;
  bit           m_accepted;
  logic [127:0] m_exp;
  logic [127:0] m_data;
  bit           m_data_known;

  always #5 clk = ~clk;

  assign rk_data = rk_rom[rk_idx];

  aes_iter_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_sbox();
    logic [2047:0] tbl;
    tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
           128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
           128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
           128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
           128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
           128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
           128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
           128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = tbl[2047-8*i -: 8];
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    for (int i = 0; i < NK; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = NK; i < 4*(NR+1); i++) begin
      tmp = w[i-1];
      if (i % NK == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (NK > 6 && i % NK == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-NK] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_rom[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Textbook AES on a 4x4 byte matrix s[row][col].
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk;
    logic [127:0] ct;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rnd = 0; rnd <= NR; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = (rnd < NR) ? (xt(t[r][c]) ^ xt(t[(r+1)%4][c]) ^ t[(r+1)%4][c] ^
                                    t[(r+2)%4][c] ^ t[(r+3)%4][c])
                                 : t[r][c];
      end
      rk = rk_rom[rnd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  task automatic model_reset();
    m_active     = 1'b0;
    m_age        = 0;
    m_accepted   = 1'b0;
    m_data       = '0;
    m_data_known = 1'b1;
  endtask

  task automatic compare();
    bit exp_busy, exp_valid, exp_ready;
    int exp_rk;
    exp_busy  = m_active && (m_age < NR);
    exp_valid = m_active && (m_age == NR);
    exp_rk    = exp_busy ? m_age + 1 : 0;
    exp_ready = !m_active || (exp_valid && out_ready);
    check("busy", busy, exp_busy);
    check("out_valid", out_valid, exp_valid);
    check("rk_idx", rk_idx, exp_rk);
    check("in_ready", in_ready, exp_ready);
    if (m_data_known) check("out_data", out_data, m_data);
  endtask

  task automatic model_update();
    m_accepted = 1'b0;
    if (flush) begin
      if (m_active && m_age < NR) m_data_known = 1'b0;
      m_active = 1'b0;
    end else if (m_active && m_age < NR) begin
      m_age++;
      if (m_age == NR) begin
        m_data       = m_exp;
        m_data_known = 1'b1;
      end
    end else if (in_valid && (!m_active || out_ready)) begin
      m_active     = 1'b1;
      m_accepted   = 1'b1;
      m_age        = 0;
      m_exp        = ref_encrypt(in_data);
      m_data_known = 1'b0;
    end else if (m_active && out_ready) begin
      m_active = 1'b0;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rst) compare();
    @(posedge clk);
    if (rst) model_update();
    cyc++;
    #1;
  endtask

  int lat;
  int done_cnt;
  int out_cyc [$];
  logic [127:0] pts [3];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fill_sbox();
    expand_key(KEY);
    model_reset();
    check("model_fips_vector", ref_encrypt(FIPS_PT), FIPS_CT);

    @(posedge clk); #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rk_idx", rk_idx, 4'd0);
    check("reset_out_data", out_data, 128'h0);
    rst = 1'b1;
    cycle();

    // Known-answer block, latency measured in edges after accept.
    in_valid = 1'b1; in_data = FIPS_PT;
    cycle();
    in_valid = 1'b0; in_data = '1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      cycle();
      lat++;
    end
    check("latency", lat, NR);
    check("fips_ciphertext", out_data, FIPS_CT);

    // Backpressure: output held, a waiting input is not taken.
    in_valid = 1'b1; in_data = 128'hdeadbeef;
    for (int i = 0; i < 5; i++) cycle();
    check("bp_data_held", out_data, FIPS_CT);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_release_idle", out_valid, 1'b0);

    // Back-to-back: three blocks with in_valid held.
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734;
    pts[1] = 128'hffffffffffffffffffffffffffffffff;
    pts[2] = 128'h0;
    in_valid = 1'b1; in_data = pts[0];
    done_cnt = 0;
    for (int i = 0; i < 5*(NR+1) && (in_valid || m_active); i++) begin
      @(negedge clk);
      compare();
      if (out_valid && out_ready) out_cyc.push_back(cyc);
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      if (m_accepted) begin
        done_cnt++;
        if (done_cnt == 3) in_valid = 1'b0;
        else in_data = pts[done_cnt];
      end
    end
    check("b2b_outputs", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      check("b2b_spacing_1", out_cyc[1] - out_cyc[0], NR + 1);
      check("b2b_spacing_2", out_cyc[2] - out_cyc[1], NR + 1);
    end

    // Flush during a round with rk_idx=4; out_valid must stay low afterwards.
    in_valid = 1'b1; in_data = pts[0];
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("pre_flush_rk_idx", rk_idx, 4'd4);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_rk_idx", rk_idx, 4'd0);
    for (int i = 0; i < NR + 4; i++) cycle();
    in_valid = 1'b1; in_data = FIPS_PT;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      cycle();
      lat++;
    end
    check("post_flush_ct", out_data, FIPS_CT);
    cycle();

    // flush and in_valid together in IDLE: no accept.
    flush = 1'b1; in_valid = 1'b1; in_data = pts[1];
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_beats_accept", busy, 1'b0);
    cycle();

    // Asynchronous reset while in the final round.
    in_valid = 1'b1; in_data = pts[1];
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < NR - 1; i++) cycle();
    check("final_rk_idx", rk_idx, NR);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rk_idx", rk_idx, 4'd0);
    check("rst_mid_out_data", out_data, 128'h0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    for (int i = 0; i < NR + 3; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
